mult_arbiter: RTL
=================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles in WAIT before the operation is aborted.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset; clock is clock.
REQ-004 req  input  2  per-requester request; bit i is held high with stable operands until done[i] or err[i].
REQ-005 a0, a1  input  16 each  multiplicand of requester 0 and 1.
REQ-006 b0, b1  input  8 each  multiplier of requester 0 and 1.
REQ-007 gnt  output  2  one-cycle pulse; operands of requester i were captured.
REQ-008 done  output  2  one-cycle pulse; result holds requester i's product.
REQ-009 err  output  2  one-cycle pulse; requester i's operation timed out, result invalid.
REQ-010 result  output  24  last product, held until the next completion.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The block SHALL share one internal mult instance (16x8->24, enable/busy/finish handshake) between two requesters.
REQ-013 The FSM SHALL have the states IDLE, ISSUE, WAIT and RECOVER.
REQ-014 IDLE: if any req bit is high, pick owner i, latch a_i/b_i into the multiplier operand registers, pulse gnt[i], assert mult enable, and go to ISSUE.
REQ-015 Arbitration SHALL be round-robin: when both req bits are high, grant the requester not served last; after reset, requester 0 wins the first tie.
REQ-016 ISSUE: mult enable SHALL stay high until mult busy is sampled high, then deassert on the next edge and go to WAIT.
REQ-017 WAIT: when mult finish is sampled high, register the mult result into result, pulse done[owner], update the last-served pointer to owner, and go to IDLE.
REQ-018 Back-to-back operation: a new grant is possible in the first IDLE cycle after done, so the minimum gap between a done and the next gnt is 1 cycle.
REQ-019 A timeout counter SHALL count the cycles spent in ISSUE+WAIT; on reaching TIMEOUT it SHALL pulse err[owner], assert mult reset for one cycle, and go to RECOVER.
REQ-020 RECOVER SHALL last exactly 1 cycle, then go to IDLE; the last-served pointer still updates to owner.
REQ-021 A req deasserted before gnt is ignored; a req deasserted after gnt does not abort, and done/err still pulse.
REQ-022 Operands SHALL be sampled only at gnt; later changes to the inputs do not affect the product.
REQ-023 At most one bit of gnt, done and err SHALL be high in any cycle; done and err are mutually exclusive.
REQ-024 Product width is 24 bits, with no truncation for a<=16'hFFFF and b<=8'hFF.

Reset
REQ-025 Reset SHALL return the block to IDLE and clear gnt, done, err, result, the timeout counter and mult enable, and set the last-served pointer to 1 (requester 0 preferred).
REQ-026 Reset SHALL also drive mult reset high in the same cycle, so that an operation in flight is discarded with no done or err pulse.
REQ-027 Reset SHALL override every other event in the same cycle.

Structure
REQ-028 State encodings and the default value of TIMEOUT SHALL live in a shared package, mult_pkg.
REQ-029 The only sub-module SHALL be the existing mult; arbitration and timeout logic stay inline.

Verification
REQ-030 Single request: req=01, a0=3, b0=5 -> gnt[0] pulse, then done[0] with result=15; gnt[1] and done[1] never pulse.
REQ-031 Simultaneous requests: req=11 from reset, a0=16'hFFFF, b0=8'hFF, a1=100, b1=7 -> done[0] with result=24'hFEFF01 first, then done[1] with result=700.
REQ-032 Fairness: req=11 held for 4 operations -> grant order is 0,1,0,1.
REQ-033 Reset mid-operation: reset asserted in WAIT -> no done/err pulse; next req=10 with a1=2, b1=2 -> result=4.
REQ-034 Timeout: a stubbed mult never finishes, TIMEOUT=8 -> err[owner] exactly 8 cycles after gnt, then IDLE one cycle later.
REQ-035 Operand change after gnt: a0 changes from 3 to 9 the cycle after gnt[0] with b0=5 -> result=15.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier arbiter: FSM encodings, widths, timeout default.
package mult_pkg;

  localparam int A_W             = 16;
  localparam int B_W             = 8;
  localparam int P_W             = 24;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/mult.sv
// Sequential 16x8 shift-add multiplier with enable/busy/finish handshake.
// Enable is sampled while idle; busy rises the next cycle, eight add/shift
// steps follow, and finish pulses for one cycle with the product valid.
// The product stays on its output until the next accepted enable.
module mult
  import mult_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           enable,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           busy,
  output logic           finish,
  output logic [P_W-1:0] product
);

  logic [P_W-1:0] mcand;
  logic [B_W-1:0] mplier;
  logic [2:0]     step;

  // Accept operands when idle, then run one add/shift step per cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      busy    <= 1'b0;
      finish  <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      step    <= '0;
      product <= '0;
    end else begin
      finish <= 1'b0;
      if (!busy) begin
        if (enable) begin
          mcand   <= {{(P_W-A_W){1'b0}}, a};
          mplier  <= b;
          product <= '0;
          step    <= '0;
          busy    <= 1'b1;
        end
      end else begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        step   <= step + 3'd1;
        if (step == 3'd7) begin
          busy   <= 1'b0;
          finish <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between two requesters,
// with a timeout that aborts a stuck operation and resets the multiplier.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [1:0]     req,
  input  logic [A_W-1:0] a0,
  input  logic [A_W-1:0] a1,
  input  logic [B_W-1:0] b0,
  input  logic [B_W-1:0] b1,
  output logic [1:0]     gnt,
  output logic [1:0]     done,
  output logic [1:0]     err,
  output logic [P_W-1:0] result,
  output logic           busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t         state, state_next;
  logic           owner, last, pick;
  logic           grant, complete, abort, timed_out;
  logic [CNT_W-1:0] cnt;
  logic [A_W-1:0] op_a;
  logic [B_W-1:0] op_b;
  logic           mult_en, mult_abort, mult_rst;
  logic           mult_busy, mult_finish;
  logic [P_W-1:0] mult_product;

  // Abort pulse lasts the RECOVER cycle; block reset also clears the multiplier
  assign mult_rst  = reset | mult_abort;
  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));
  assign busy      = (state != IDLE);

  mult u_mult (
    .clock   (clock),
    .reset   (mult_rst),
    .enable  (mult_en),
    .a       (op_a),
    .b       (op_b),
    .busy    (mult_busy),
    .finish  (mult_finish),
    .product (mult_product)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and one-cycle strobes; on a tie the requester not served last wins
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    pick       = owner;
    case (state)
      IDLE: begin
        if (|req) begin
          grant      = 1'b1;
          pick       = (req == 2'b11) ? ~last : req[1];
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (timed_out) begin
          abort      = 1'b1;
          state_next = RECOVER;
        end else if (mult_busy) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mult_finish) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (timed_out) begin
          abort      = 1'b1;
          state_next = RECOVER;
        end
      end
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, handshake, timeout count and result/pulse registers
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt        <= '0;
      done       <= '0;
      err        <= '0;
      result     <= '0;
      cnt        <= '0;
      mult_en    <= 1'b0;
      mult_abort <= 1'b0;
      owner      <= 1'b0;
      last       <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
    end else begin
      gnt        <= {grant & pick, grant & ~pick};
      done       <= {complete & owner, complete & ~owner};
      err        <= {abort & owner, abort & ~owner};
      mult_abort <= abort;
      if (state == ISSUE || state == WAIT) cnt <= cnt + 1'b1;
      if (grant) begin
        owner   <= pick;
        op_a    <= pick ? a1 : a0;
        op_b    <= pick ? b1 : b0;
        mult_en <= 1'b1;
        cnt     <= '0;
      end
      if ((state == ISSUE && mult_busy) || abort) mult_en <= 1'b0;
      if (complete) begin
        result <= mult_product;
        last   <= owner;
      end
      if (abort) last <= owner;
    end
  end

endmodule
